// File: rtl/pe_pkg.sv
// Shared constants, state encoding and the optional ReLU helper for the PE-column psum drain.
package pe_pkg;

   localparam int DEF_DATA_WIDTH = 32;
   localparam logic [DEF_DATA_WIDTH-1:0] FP_POS_ZERO = '0;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      DRAIN   = 2'd2,
      DONE    = 2'd3
   } drain_state_e;

   // Negative values clamp to +0.0; NaN of either sign passes through so upstream faults stay visible.
   function automatic logic [DEF_DATA_WIDTH-1:0] fp_relu(input logic [DEF_DATA_WIDTH-1:0] w);
      logic is_nan;
      is_nan = (w[30:23] == 8'hFF) && (w[22:0] != '0);
      return (w[31] && !is_nan) ? FP_POS_ZERO : w;
   endfunction

endpackage

// File: rtl/psum_drain_if.sv
// Output stream of the psum drain: first-word-fall-through head with a valid/ready handshake.
interface psum_drain_if #(
   parameter int DATA_WIDTH = pe_pkg::DEF_DATA_WIDTH
);
   logic [DATA_WIDTH-1:0] o_data;
   logic                  o_valid;
   logic                  i_ready;

   modport master (output o_data, output o_valid, input i_ready);
   modport slave  (input o_data, input o_valid, output i_ready);
endinterface

// File: rtl/psum_fifo.sv
// Synchronous first-word-fall-through FIFO; a push into a full FIFO is taken only if a pop frees a slot that cycle.
module psum_fifo #(
   parameter  int DATA_WIDTH = 32,
   parameter  int FIFO_DEPTH = 16,
   localparam int AW         = $clog2(FIFO_DEPTH),
   localparam int CW         = AW + 1
) (
   input  logic                  i_clk,
   input  logic                  i_rest_n,
   input  logic                  i_push,
   input  logic [DATA_WIDTH-1:0] i_push_data,
   input  logic                  i_pop,
   output logic [DATA_WIDTH-1:0] o_head,
   output logic [CW-1:0]         o_count,
   output logic                  o_full,
   output logic                  o_empty
);

   logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
   logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]         count_q, count_d;
   logic                  do_push, do_pop;

   assign o_empty = (count_q == '0);
   assign o_full  = (count_q == CW'(FIFO_DEPTH));
   assign do_pop  = i_pop && !o_empty;
   assign do_push = i_push && (!o_full || do_pop);

   // NOTE: every variable gets its default first so no path leaves it unassigned (no latch).
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   // NOTE: storage is not reset; occupancy lives in the pointers and count, so stale entries are never read.
   always_ff @(posedge i_clk) begin
      if (do_push) mem_q[wr_ptr_q] <= i_push_data;
   end

   // NOTE: state flops use non-blocking assignments so all of them sample pre-edge values.
   always_ff @(posedge i_clk or negedge i_rest_n) begin
      if (!i_rest_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   assign o_head  = mem_q[rd_ptr_q];
   assign o_count = count_q;

endmodule

// File: rtl/psum_drain.sv
// Bottom-of-column psum drain: tracks issues through the PE pipeline, captures results into a FWFT FIFO,
// streams them out and grants issue credits. Define PSUM_DRAIN_RELU_EN to clamp negative psums to +0.0 on push.
module psum_drain
   import pe_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int PIPE_LAT   = 16,
   parameter int FIFO_DEPTH = 16,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  i_clk,
   input  logic                  i_rest_n,
   input  logic                  i_start,
   input  logic [CNT_WIDTH-1:0]  i_num_out,
   input  logic                  i_issue,
   input  logic [DATA_WIDTH-1:0] i_psum,
   output logic                  o_issue_ok,
   psum_drain_if.master          out_if,
   output logic                  o_busy,
   output logic                  o_done,
   output logic                  o_overflow
);

   localparam int FCW = $clog2(FIFO_DEPTH) + 1;
   localparam int IFW = $clog2(PIPE_LAT + 1);

   drain_state_e          state_q, state_d;
   logic [CNT_WIDTH-1:0]  num_out_q, num_out_d;
   logic [CNT_WIDTH-1:0]  issued_q, issued_d;
   logic [CNT_WIDTH-1:0]  captured_q, captured_d;
   logic [PIPE_LAT-1:0]   pipe_q, pipe_d;
   logic [IFW-1:0]        inflight_q, inflight_d;
   logic                  overflow_q, overflow_d;
   logic                  done_q;

   logic                  want_more, track, capture, pop, drop, room;
   logic [DATA_WIDTH-1:0] push_data, fifo_head;
   logic [FCW-1:0]        fifo_count;
   logic                  fifo_full, fifo_empty;

   assign want_more = (state_q == COLLECT) && (issued_q < num_out_q);
   assign track     = i_issue && want_more;
   assign capture   = pipe_q[PIPE_LAT-1];
   assign pop       = out_if.o_valid && out_if.i_ready;
   assign drop      = capture && fifo_full && !pop;
   assign room      = (int'(fifo_count) + int'(inflight_q)) < FIFO_DEPTH;

   // A credit covers both buffered words and every tracked issue still travelling down the pipeline.
   assign o_issue_ok = want_more && room;

   generate
      if (PIPE_LAT == 1) begin : g_pipe_short
         assign pipe_d = track;
      end else begin : g_pipe_long
         assign pipe_d = {pipe_q[PIPE_LAT-2:0], track};
      end
   endgenerate

   always_comb begin
      inflight_d = inflight_q;
      case ({track, capture})
         2'b10:   inflight_d = inflight_q + IFW'(1);
         2'b01:   inflight_d = inflight_q - IFW'(1);
         default: inflight_d = inflight_q;
      endcase
   end

`ifdef PSUM_DRAIN_RELU_EN
   assign push_data = fp_relu(i_psum);
`else
   assign push_data = i_psum;
`endif

   always_comb begin
      state_d    = state_q;
      num_out_d  = num_out_q;
      issued_d   = issued_q;
      captured_d = captured_q;
      overflow_d = overflow_q;
      if (track)   issued_d   = issued_q + CNT_WIDTH'(1);
      if (capture) captured_d = captured_q + CNT_WIDTH'(1);
      if (drop)    overflow_d = 1'b1;
      unique case (state_q)
         IDLE: begin
            if (i_start) begin
               num_out_d  = i_num_out;
               issued_d   = '0;
               captured_d = '0;
               overflow_d = 1'b0;
               state_d    = (i_num_out == '0) ? DONE : COLLECT;
            end
         end
         COLLECT: if (captured_d == num_out_q) state_d = DRAIN;
         DRAIN:   if (fifo_empty || (pop && fifo_count == FCW'(1))) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rest_n) begin
      if (!i_rest_n) begin
         state_q    <= IDLE;
         num_out_q  <= '0;
         issued_q   <= '0;
         captured_q <= '0;
         pipe_q     <= '0;
         inflight_q <= '0;
         overflow_q <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         num_out_q  <= num_out_d;
         issued_q   <= issued_d;
         captured_q <= captured_d;
         pipe_q     <= pipe_d;
         inflight_q <= inflight_d;
         overflow_q <= overflow_d;
         // Registered pulse, high the cycle after the DONE state so it is glitch-free.
         done_q     <= (state_q == DONE);
      end
   end

   psum_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .i_clk       (i_clk),
      .i_rest_n    (i_rest_n),
      .i_push      (capture),
      .i_push_data (push_data),
      .i_pop       (pop),
      .o_head      (fifo_head),
      .o_count     (fifo_count),
      .o_full      (fifo_full),
      .o_empty     (fifo_empty)
   );

   assign out_if.o_valid = !fifo_empty;
   assign out_if.o_data  = fifo_empty ? FP_POS_ZERO : fifo_head;
   assign o_busy         = (state_q != IDLE);
   assign o_done         = done_q;
   assign o_overflow     = overflow_q;

endmodule

// File: tb/tb_psum_drain.sv
// Self-checking bench for psum_drain: vector table, directed multi-cycle corners and randomized tiles
// checked against a queue-based model of the capture/buffer/credit rules.
`timescale 1ns/1ps
module tb_psum_drain;

   localparam int DW = 32;
   localparam int PL = 4;
   localparam int FD = 16;
   localparam int CW = 16;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic          issue = 1'b0;
   logic [CW-1:0] num_out = '0;
   logic [DW-1:0] psum = '0;
   logic          issue_ok, busy, done, overflow;

   psum_drain_if #(.DATA_WIDTH(DW)) out_if ();

   psum_drain #(
      .DATA_WIDTH (DW),
      .PIPE_LAT   (PL),
      .FIFO_DEPTH (FD),
      .CNT_WIDTH  (CW)
   ) dut (
      .i_clk      (clk),
      .i_rest_n   (rst_n),
      .i_start    (start),
      .i_num_out  (num_out),
      .i_issue    (issue),
      .i_psum     (psum),
      .o_issue_ok (issue_ok),
      .out_if     (out_if),
      .o_busy     (busy),
      .o_done     (done),
      .o_overflow (overflow)
   );

   always #5 clk = ~clk;

   int          n_cmp = 0;
   int          n_fail = 0;
   bit          ovf_model = 1'b0;
   logic [31:0] fixed_words[$];
   logic [31:0] last_out;
   int          delivered;
   int          stall_cycles;

   typedef struct {
      logic [31:0] psum;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs[8];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %08h expected %08h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Value the drain should store for a captured word.
   function automatic logic [31:0] model_store(input logic [31:0] w);
`ifdef PSUM_DRAIN_RELU_EN
      if (w[31] && !(w[30:23] == 8'hFF && w[22:0] != 23'd0)) return 32'h0;
`endif
      return w;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One tile. Called and returns at posedge+1. restart_at / reset_at < 0 disable those events.
   task automatic run_tile(input int n, input bit ignore_ok, input int issue_pct,
                           input int ready_hold, input int ready_pct,
                           input int restart_at, input int reset_at);
      logic [31:0] q[$];
      int          pend[$];
      int          issued = 0;
      int          captured = 0;
      bit          collecting = 1'b0;
      bit          seen_done = 1'b0;
      bit          rdy, iss, pop_now, cap_now, full_before, tracked;
      logic [31:0] word;
      delivered    = 0;
      stall_cycles = 0;
      for (int c = 0; c < 3000 && !seen_done; c++) begin
         if (c == reset_at) begin
            rst_n = 1'b0;
            #1;
            check("reset_valid", 32'(out_if.o_valid), 32'(0));
            check("reset_busy", 32'(busy), 32'(0));
            check("reset_issue_ok", 32'(issue_ok), 32'(0));
            check("reset_data", out_if.o_data, 32'h0);
            ovf_model = 1'b0;
            start = 1'b0;
            issue = 1'b0;
            out_if.i_ready = 1'b0;
            repeat (2) @(posedge clk);
            #1 rst_n = 1'b1;
            return;
         end
         check("issue_ok", 32'(issue_ok), 32'(collecting && issued < n && (q.size() + pend.size()) < FD));
         check("valid", 32'(out_if.o_valid), 32'(q.size() != 0));
         if (q.size() != 0) check("data", out_if.o_data, q[0]);
         check("overflow", 32'(overflow), 32'(ovf_model));
         if (collecting) check("busy", 32'(busy), 32'(1));
         if (collecting && issued < n && !issue_ok) stall_cycles++;
         if (done) begin
            seen_done = 1'b1;
            check("done_when_drained", 32'(q.size() == 0 && !collecting && captured == n), 32'(1));
            if (n == 0) check("zero_len_done_cycle", 32'(c), 32'(2));
         end

         start   = (c == 0) || (c == restart_at);
         num_out = (c == 0) ? CW'(n) : CW'(n + 5);
         rdy     = (c >= ready_hold) && ($urandom_range(99) < ready_pct);
         iss     = $urandom_range(99) < issue_pct;
         if (!ignore_ok && issued < n) iss = iss && issue_ok;
         cap_now = (pend.size() != 0) && (pend[0] == c);
         if (cap_now && fixed_words.size() != 0) word = fixed_words.pop_front();
         else word = $urandom();
         out_if.i_ready = rdy;
         issue = iss;
         psum  = word;

         tracked     = iss && collecting && issued < n;
         pop_now     = rdy && (q.size() != 0);
         full_before = (q.size() == FD);
         if (pop_now) begin
            last_out = q.pop_front();
            delivered++;
         end
         if (cap_now) begin
            pend.delete(0);
            captured++;
            if (!full_before || pop_now) q.push_back(model_store(word));
            else ovf_model = 1'b1;
            if (captured == n) collecting = 1'b0;
         end
         if (tracked) begin
            pend.push_back(c + PL);
            issued++;
         end
         if (c == 0) begin
            collecting = (n != 0);
            ovf_model  = 1'b0;
         end
         tick();
      end
      start = 1'b0;
      issue = 1'b0;
      check("done_seen", 32'(seen_done), 32'(1));
      check("done_single_pulse", 32'(done), 32'(0));
      check("busy_after_done", 32'(busy), 32'(0));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      vecs[0] = '{32'h3F800000, 32'h3F800000};
      vecs[1] = '{32'h40000000, 32'h40000000};
      vecs[2] = '{32'h7FC00000, 32'h7FC00000};
      vecs[3] = '{32'h00000000, 32'h00000000};
`ifdef PSUM_DRAIN_RELU_EN
      vecs[4] = '{32'hBF800000, 32'h00000000};
      vecs[5] = '{32'h80000000, 32'h00000000};
      vecs[6] = '{32'hFFC00001, 32'hFFC00001};
      vecs[7] = '{32'hFF800000, 32'h00000000};
`else
      vecs[4] = '{32'hBF800000, 32'hBF800000};
      vecs[5] = '{32'h80000000, 32'h80000000};
      vecs[6] = '{32'hFFC00001, 32'hFFC00001};
      vecs[7] = '{32'hFF800000, 32'hFF800000};
`endif
      out_if.i_ready = 1'b0;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_hold_busy", 32'(busy), 32'(0));
      rst_n = 1'b1;
      tick();
      check("rst_valid", 32'(out_if.o_valid), 32'(0));
      check("rst_data", out_if.o_data, 32'h0);
      check("rst_busy", 32'(busy), 32'(0));
      check("rst_done", 32'(done), 32'(0));
      check("rst_overflow", 32'(overflow), 32'(0));
      check("rst_issue_ok", 32'(issue_ok), 32'(0));

      // Basic tile: three back-to-back issues, consumer always ready
      fixed_words = '{32'h3F800000, 32'h40000000, 32'h40400000};
      run_tile(3, 1'b0, 100, 0, 100, -1, -1);
      check("basic_delivered", 32'(delivered), 32'(3));
      check("basic_last_word", last_out, 32'h40400000);

      // Single-word vectors, including sign and NaN corners
      foreach (vecs[i]) begin
         fixed_words = '{vecs[i].psum};
         run_tile(1, 1'b0, 100, 0, 100, -1, -1);
         check("vec_out", last_out, vecs[i].exp);
      end

      // Backpressure: credits stop at buffer capacity, nothing lost
      run_tile(20, 1'b0, 100, 40, 100, -1, -1);
      check("bp_stalled", 32'(stall_cycles > 0), 32'(1));
      check("bp_delivered", 32'(delivered), 32'(20));
      check("bp_overflow", 32'(overflow), 32'(0));

      // Overflow: 17 forced issues into a stalled 16-entry buffer
      run_tile(17, 1'b1, 100, 40, 100, -1, -1);
      check("ovf_delivered", 32'(delivered), 32'(16));
      check("ovf_sticky", 32'(overflow), 32'(1));

      // Zero-length tile clears the sticky overflow and completes on its own
      run_tile(0, 1'b0, 100, 0, 100, -1, -1);
      check("zero_len_ovf_cleared", 32'(overflow), 32'(0));

      // Start while collecting is ignored
      run_tile(4, 1'b0, 100, 0, 100, 2, -1);
      check("busy_start_delivered", 32'(delivered), 32'(4));

      // Reset mid-tile with words in flight and buffered, then a clean tile
      run_tile(10, 1'b0, 100, 50, 0, -1, 10);
      check("post_reset_valid", 32'(out_if.o_valid), 32'(0));
      check("post_reset_busy", 32'(busy), 32'(0));
      fixed_words = '{32'h3F800000, 32'h40000000, 32'h40400000};
      run_tile(3, 1'b0, 100, 0, 100, -1, -1);
      check("post_reset_delivered", 32'(delivered), 32'(3));

      // Randomized tiles; every fourth one ignores the credit and may overflow
      for (int t = 0; t < 12; t++) begin
         run_tile($urandom_range(40, 1), (t % 4) == 3, $urandom_range(100, 30),
                  $urandom_range(30, 0), $urandom_range(100, 20), -1, -1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
